// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter: shares one bridge port between icache and dcache; dcache priority, or round-robin with YSYX_22040759_ARB_RR_EN
module ysyx_22040759_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_valid,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_valid,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic [2:0]        dc_size,
  output logic              dc_ready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_size,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic grant;
  logic pick_dc;
`ifdef YSYX_22040759_ARB_RR_EN
  logic last_grant;
  assign pick_dc = dc_valid & (~ic_valid | ~last_grant);
  always_ff @(posedge clock)
    if (reset) last_grant <= 1'b0;
    else if (state == IDLE && (ic_valid || dc_valid)) last_grant <= pick_dc;
`else
  assign pick_dc = dc_valid;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      mem_valid <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= 3'd0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      case (state)
        IDLE: if (ic_valid || dc_valid) begin
          state     <= BUSY;
          grant     <= pick_dc;
          mem_valid <= 1'b1;
          mem_req   <= pick_dc & dc_req;
          mem_addr  <= pick_dc ? dc_addr : ic_addr;
          mem_wdata <= pick_dc ? dc_wdata : '0;
          mem_size  <= pick_dc ? dc_size : 3'd3;
        end
        BUSY: if (mem_ready) begin
          state     <= RESP;
          mem_valid <= 1'b0;
          ic_ready  <= ~grant;
          dc_ready  <= grant;
          if (grant) dc_rdata <= mem_rdata;
          else ic_rdata <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// tb_ysyx_22040759_mem_arbiter: transaction-model bench for the memory arbiter
module tb_ysyx_22040759_mem_arbiter;
  logic clock = 0, reset = 1;
  logic ic_valid = 0, ic_ready;
  logic [31:0] ic_addr = 0;
  logic [63:0] ic_rdata;
  logic dc_valid = 0, dc_req = 0, dc_ready;
  logic [31:0] dc_addr = 0;
  logic [63:0] dc_wdata = 0, dc_rdata;
  logic [2:0] dc_size = 0;
  logic mem_valid, mem_req, mem_ready = 0;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata = 0;
  logic [2:0] mem_size;

  ysyx_22040759_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_valid(dc_valid), .dc_req(dc_req), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_size(dc_size), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

`ifdef YSYX_22040759_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        dc;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
  } txn_t;
  txn_t cur;
  logic m_wait, m_resp, m_last_dc, take_dc;
  logic e_ic_ready, e_dc_ready;
  logic [63:0] e_ic_rdata, e_dc_rdata;

  // One outstanding transaction: accepted when idle, finished by the bridge, announced for one cycle.
  assign take_dc = dc_valid && !(RR && ic_valid && m_last_dc);
  always @(posedge clock) begin
    e_ic_ready <= 1'b0;
    e_dc_ready <= 1'b0;
    if (reset) begin
      m_wait <= 1'b0;
      m_resp <= 1'b0;
      m_last_dc <= 1'b0;
      e_ic_rdata <= '0;
      e_dc_rdata <= '0;
    end else if (m_resp) m_resp <= 1'b0;
    else if (m_wait) begin
      if (mem_ready) begin
        m_wait <= 1'b0;
        m_resp <= 1'b1;
        if (cur.dc) begin e_dc_rdata <= mem_rdata; e_dc_ready <= 1'b1; end
        else begin e_ic_rdata <= mem_rdata; e_ic_ready <= 1'b1; end
      end
    end else if (ic_valid || dc_valid) begin
      cur <= take_dc ? {1'b1, dc_req, dc_addr, dc_wdata, dc_size} : {1'b0, 1'b0, ic_addr, 64'd0, 3'd3};
      m_last_dc <= take_dc;
      m_wait <= 1'b1;
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0;
  int ic_nreq = 0, ic_ndone = 0, dc_nreq = 0, dc_ndone = 0;
  int ic_pulses = 0, dc_pulses = 0, busy_cnt = 0, br_lat = 1;
  int mr_cyc = 0, dc_rdy_cyc = 0, t0 = 0;
  bit chk_en = 0;
  logic mv_prev = 0;
  logic seen_req;
  logic [31:0] seen_addr;
  logic [63:0] seen_wdata;
  logic [2:0] seen_size;
  logic [31:0] rise_addr[$];
  int rise_cyc[$], rdy_q[$];
  logic [31:0] exp_order[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Advance one cycle: compare against the model, then act as requesters and bridge.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (chk_en) begin
      chk("mem_valid", mem_valid, m_wait);
      if (m_wait) begin
        chk("mem_req", mem_req, cur.wr);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_size", mem_size, cur.size);
      end
      chk("ic_ready", ic_ready, e_ic_ready);
      chk("dc_ready", dc_ready, e_dc_ready);
      chk("ic_rdata", ic_rdata, e_ic_rdata);
      chk("dc_rdata", dc_rdata, e_dc_rdata);
    end
    if (mem_valid && !mv_prev) begin rise_addr.push_back(mem_addr); rise_cyc.push_back(cyc); end
    mv_prev = mem_valid;
    if (mem_valid) begin seen_req = mem_req; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_size = mem_size; end
    if (ic_ready) begin ic_ndone++; ic_pulses++; rdy_q.push_back(cyc); end
    if (dc_ready) begin dc_ndone++; dc_pulses++; dc_rdy_cyc = cyc; rdy_q.push_back(cyc); end
    ic_valid = ic_ndone < ic_nreq;
    dc_valid = dc_ndone < dc_nreq;
    busy_cnt = mem_valid ? busy_cnt + 1 : 0;
    mem_ready = mem_valid && busy_cnt == br_lat;
    if (mem_ready) mr_cyc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((ic_ndone != ic_nreq || dc_ndone != dc_nreq) && n < 300) begin tick(); n++; end
    chk("done_in_time", 64'(ic_ndone == ic_nreq && dc_ndone == dc_nreq), 64'd1);
    repeat (2) tick();
  endtask

  task automatic clear_log();
    rise_addr.delete();
    rise_cyc.delete();
    rdy_q.delete();
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    ic_nreq = ic_ndone; dc_nreq = dc_ndone;
    ic_valid = 0; dc_valid = 0;
  endtask

  initial begin
    int n, dp;
    repeat (2) tick();
    chk_en = 1;
    chk("rst_mem_valid", mem_valid, 64'd0);
    chk("rst_mem_req", mem_req, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_size", mem_size, 64'd0);
    chk("rst_ic_rdata", ic_rdata, 64'd0);
    chk("rst_dc_rdata", dc_rdata, 64'd0);
    reset = 0;
    tick();

    // icache read alone, bridge answers in the third busy cycle
    clear_log();
    br_lat = 3; mem_rdata = 64'h0000001300000093;
    ic_addr = 32'h8000_0000; ic_nreq++; ic_valid = 1;
    wait_done();
    chk("ic_read_data", ic_rdata, 64'h0000001300000093);
    chk("ic_read_pulses", ic_pulses, 64'd1);
    chk("ic_read_dc_quiet", dc_pulses, 64'd0);
    chk("ic_read_req", seen_req, 64'd0);
    chk("ic_read_size", seen_size, 64'd3);
    chk("ic_read_addr", seen_addr, 64'h8000_0000);
    chk("ic_read_episodes", rise_addr.size(), 64'd1);

    // dcache write passes through
    clear_log();
    br_lat = 2; mem_rdata = 64'h1111_2222_3333_4444;
    dc_req = 1; dc_addr = 32'h8000_1000; dc_wdata = 64'hDEADBEEF; dc_size = 3'd2;
    dc_nreq++; dc_valid = 1;
    wait_done();
    chk("dc_wr_req", seen_req, 64'd1);
    chk("dc_wr_addr", seen_addr, 64'h8000_1000);
    chk("dc_wr_wdata", seen_wdata, 64'hDEADBEEF);
    chk("dc_wr_size", seen_size, 64'd2);
    chk("dc_wr_pulses", dc_pulses, 64'd1);
    chk("dc_wr_latency", dc_rdy_cyc - mr_cyc, 64'd1);
    chk("dc_wr_ic_hold", ic_rdata, 64'h0000001300000093);

    // simultaneous requests: dcache first, icache right after
    do_reset();
    clear_log();
    br_lat = 1; mem_rdata = 64'h5555_6666_7777_8888;
    dc_req = 0; dc_addr = 32'h8000_2000; ic_addr = 32'h8000_3000;
    dc_nreq++; ic_nreq++; dc_valid = 1; ic_valid = 1;
    wait_done();
    chk("sim_episodes", rise_addr.size(), 64'd2);
    chk("sim_first", rise_addr[0], 64'h8000_2000);
    chk("sim_second", rise_addr[1], 64'h8000_3000);
    chk("sim_gap", rise_cyc[1] - dc_rdy_cyc, 64'd2);

    // continuous contention, two requests each
    do_reset();
    clear_log();
    br_lat = 2;
    dc_nreq += 2; ic_nreq += 2; dc_valid = 1; ic_valid = 1;
    wait_done();
    if (RR) exp_order = '{32'h8000_2000, 32'h8000_3000, 32'h8000_2000, 32'h8000_3000};
    else exp_order = '{32'h8000_2000, 32'h8000_2000, 32'h8000_3000, 32'h8000_3000};
    chk("cont_episodes", rise_addr.size(), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), rise_addr[i], exp_order[i]);

    // reset while busy abandons the transfer
    clear_log();
    br_lat = 50;
    dc_nreq++; dc_valid = 1;
    n = 0;
    while (!mem_valid && n < 10) begin tick(); n++; end
    chk("rst_busy_seen", mem_valid, 64'd1);
    tick();
    dp = dc_pulses;
    reset = 1;
    tick();
    chk("rst_busy_drop", mem_valid, 64'd0);
    reset = 0;
    dc_nreq = dc_ndone; dc_valid = 0;
    repeat (3) tick();
    chk("rst_busy_no_pulse", dc_pulses, dp);
    br_lat = 2; mem_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    ic_nreq++; ic_valid = 1;
    wait_done();
    chk("rst_busy_ic_after", ic_rdata, 64'hCAFE_F00D_0BAD_BEEF);

    // minimum latency, back-to-back icache requests
    clear_log();
    br_lat = 1;
    ic_nreq += 2; ic_valid = 1; t0 = cyc;
    wait_done();
    chk("min_episodes", rise_cyc.size(), 64'd2);
    chk("min_valid_lat", rise_cyc[0] - t0, 64'd1);
    chk("min_ready_lat", rdy_q[0] - t0, 64'd2);
    chk("min_next_valid", rise_cyc[1] - t0, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
